// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset vector and fetch-state encoding for the instruction fetch stage.
package inst_fetch_pkg;
    localparam int F_D_WID  = 35;
    localparam int BRAN_WID = 33;
    localparam logic [31:0] PC_RST_VEC_DEF = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_RUN     = 2'd1,
        FS_BR_PEND = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/inst_fetch_br_pend_buf.sv
// Pending-redirect FSM: keeps a branch target resolved while Fetch is stalled
// until Fetch can consume it; a flush drops it.
module br_pend_buf
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        flush,
    input  logic        br_en,
    input  logic [31:0] br_addr,
    output logic        idle,
    output logic        pend_valid,
    output logic [31:0] pend_addr
);
    fetch_state_t state_reg, state_next;
    logic [31:0]  pend_addr_reg, pend_addr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FS_IDLE;
            pend_addr_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            pend_addr_reg <= pend_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pend_addr_next = pend_addr_reg;
        case (state_reg)
            FS_IDLE: state_next = FS_RUN;
            FS_RUN: begin
                if (!flush && stall_f && br_en) begin
                    state_next     = FS_BR_PEND;
                    pend_addr_next = br_addr;
                end
            end
            FS_BR_PEND: begin
                // Only the first captured target survives; later br_en under stall is ignored.
                if (flush) begin
                    state_next     = FS_RUN;
                    pend_addr_next = 32'd0;
                end else if (!stall_f) begin
                    state_next = FS_RUN;
                end
            end
            default: state_next = FS_IDLE;
        endcase
    end

    assign idle       = (state_reg == FS_IDLE);
    assign pend_valid = (state_reg == FS_BR_PEND);
    assign pend_addr  = pend_addr_reg;
endmodule

// File: rtl/inst_fetch.sv
// MIPS fetch stage: PC register, next-PC selection and F_D_bus packing.
// Optional misaligned-fetch detection is enabled with `define FETCH_ADEL_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RST_VEC = PC_RST_VEC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [31:0]         new_pc,
    input  logic [BRAN_WID-1:0] bran_bus,
    input  logic                next_delayslot_judge_i,
    output logic                inst_sram_en,
    output logic [3:0]          inst_sram_wen,
    output logic [31:0]         inst_sram_addr,
    output logic [31:0]         inst_sram_wdata,
    output logic [F_D_WID-1:0]  F_D_bus
);
    logic [31:0] pc_reg, pc_next;
    logic        ce_reg;
    logic        br_en;
    logic [31:0] br_addr;
    logic        idle, pend_valid;
    logic [31:0] pend_addr;
    logic        f_adel;
    logic        delayslot;
    logic        unused_stall;

    assign br_en        = bran_bus[32];
    assign br_addr      = bran_bus[31:0];
    assign unused_stall = ^stall[5:1];

    br_pend_buf u_br_pend_buf (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall[0]),
        .flush      (flush),
        .br_en      (br_en),
        .br_addr    (br_addr),
        .idle       (idle),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr)
    );

    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (idle)
            pc_next = PC_RST_VEC;
        else if (flush)
            pc_next = new_pc;
        else if (stall[0])
            pc_next = pc_reg;
        else if (pend_valid)
            pc_next = pend_addr;
        else if (br_en)
            pc_next = br_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= PC_RST_VEC - 32'd4;
            ce_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            if (idle)
                ce_reg <= 1'b1;
        end
    end

`ifdef FETCH_ADEL_EN
    assign f_adel = (pc_reg[1:0] != 2'b00) & ce_reg;
`else
    assign f_adel = 1'b0;
`endif

    // Decode may have moved past the branch while the target waits; pc_reg is still its slot.
    assign delayslot       = next_delayslot_judge_i | pend_valid;
    assign inst_sram_en    = ce_reg & ~f_adel;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'd0;
    assign F_D_bus         = {f_adel, delayslot, ce_reg, pc_reg};
endmodule
